branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 13 +
 rtl/branch_resolve_unit_if.sv | 27 ++
 rtl/branch_lane_eval.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: RV32I control-flow opcodes, branch funct3 codes and resolver FSM states.
package branch_pkg;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [2:0] F3_BLT    = 3'b100;
   localparam logic [2:0] F3_BGE    = 3'b101;
   localparam logic [2:0] F3_BLTU   = 3'b110;
   localparam logic [2:0] F3_BGEU   = 3'b111;
   typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: issue-lane inputs and redirect/predictor-update outputs of the resolver.
interface branch_resolve_unit_if #(parameter int NUM_LANES = 2, parameter int XLEN = 32);
   logic [NUM_LANES-1:0]      in_valid;
   logic [NUM_LANES*32-1:0]   in_instr;
   logic [NUM_LANES*XLEN-1:0] in_pc;
   logic [NUM_LANES*XLEN-1:0] in_rs1;
   logic [NUM_LANES*XLEN-1:0] in_rs2;
   logic [NUM_LANES-1:0]      in_pred_taken;
   logic [NUM_LANES*XLEN-1:0] in_pred_target;
   logic                      busy;
   logic                      redirect_valid;
   logic [XLEN-1:0]           redirect_pc;
   logic [NUM_LANES-1:0]      upd_valid;
   logic [NUM_LANES-1:0]      upd_taken;
   logic [NUM_LANES-1:0]      upd_is_branch;
   logic [NUM_LANES-1:0]      upd_is_jump;
   logic [NUM_LANES*XLEN-1:0] upd_pc;
   logic [NUM_LANES*XLEN-1:0] upd_target;
   modport master (
      output in_valid, in_instr, in_pc, in_rs1, in_rs2, in_pred_taken, in_pred_target,
      input  busy, redirect_valid, redirect_pc, upd_valid, upd_taken, upd_is_branch, upd_is_jump, upd_pc, upd_target
   );
   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1, in_rs2, in_pred_taken, in_pred_target,
      output busy, redirect_valid, redirect_pc, upd_valid, upd_taken, upd_is_branch, upd_is_jump, upd_pc, upd_target
   );
endinterface

// File: rtl/branch_lane_eval.sv
// branch_lane_eval: combinational decode, condition, target and mispredict check for one issue lane.
module branch_lane_eval import branch_pkg::*; #(parameter int XLEN = 32) (
   input  logic            valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_target,
   output logic            is_branch,
   output logic            is_jump,
   output logic            taken,
   output logic            mispred,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] next_pc
);
   logic [6:0] op;
   logic [2:0] f3;
   logic [31:0] imm_j, imm_i, imm_b;
   logic [XLEN-1:0] jalr_sum;
   logic jal, jalr, cond, lt, ltu;
   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign jal = op == OP_JAL;
   assign jalr = op == OP_JALR;
   assign is_branch = op == OP_BRANCH && f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
   assign is_jump = jal | jalr;
   assign lt = $signed(rs1) < $signed(rs2);
   assign ltu = rs1 < rs2;
   assign cond = f3 == F3_BEQ ? rs1 == rs2 :
                 f3 == F3_BNE ? rs1 != rs2 :
                 f3 == F3_BLT ? lt :
                 f3 == F3_BGE ? !lt :
                 f3 == F3_BLTU ? ltu : !ltu;
   assign jalr_sum = rs1 + XLEN'($signed(imm_i));
   assign target = jal ? pc + XLEN'($signed(imm_j)) :
                   jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + XLEN'($signed(imm_b));
   assign taken = is_jump | (is_branch & cond);
   assign next_pc = taken ? target : pc + XLEN'(4);
   // A non-control lane predicted taken sent fetch astray, so it redirects to pc+4.
   assign mispred = valid & ((is_branch | is_jump) ? (taken != pred_taken || (taken && target != pred_target)) : pred_taken);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves per-lane branches, redirects fetch on the oldest mispredict, then squashes.
// Define BRANCH_STATS_EN to add saturating stat_branches / stat_mispredicts counters.
module branch_resolve_unit import branch_pkg::*; #(
   parameter int NUM_LANES    = 2,
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);
   localparam logic [3:0] FC = 4'(FLUSH_CYCLES);
   logic [NUM_LANES-1:0] br, jmp, tk, mis, keep;
   logic [XLEN-1:0] tgt [NUM_LANES];
   logic [XLEN-1:0] nxt [NUM_LANES];
   logic [XLEN-1:0] win_pc;
   logic hit, run, fire;
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   genvar g;
   for (g = 0; g < NUM_LANES; g++) begin : g_lane
      branch_lane_eval #(.XLEN(XLEN)) u_eval (
         .valid(bus.in_valid[g]), .instr(bus.in_instr[g*32 +: 32]), .pc(bus.in_pc[g*XLEN +: XLEN]),
         .rs1(bus.in_rs1[g*XLEN +: XLEN]), .rs2(bus.in_rs2[g*XLEN +: XLEN]),
         .pred_taken(bus.in_pred_taken[g]), .pred_target(bus.in_pred_target[g*XLEN +: XLEN]),
         .is_branch(br[g]), .is_jump(jmp[g]), .taken(tk[g]), .mispred(mis[g]),
         .target(tgt[g]), .next_pc(nxt[g])
      );
   end
   // Lanes after the oldest mispredict are on the wrong path and are dropped.
   always_comb begin
      hit = 1'b0;
      win_pc = '0;
      keep = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         keep[i] = bus.in_valid[i] & (br[i] | jmp[i]) & ~hit;
         win_pc = (!hit && mis[i]) ? nxt[i] : win_pc;
         hit = hit | mis[i];
      end
   end
   assign run = state == RUN;
   assign fire = run & hit;
   always_comb begin
      state_n = run ? ((fire && FC != 4'd0) ? FLUSH : RUN) : (cnt == 4'd1 ? RUN : FLUSH);
      cnt_n = run ? (fire ? FC : cnt) : cnt - 4'd1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy <= 1'b0;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc <= '0;
         bus.upd_valid <= '0;
         bus.upd_taken <= '0;
         bus.upd_is_branch <= '0;
         bus.upd_is_jump <= '0;
         bus.upd_pc <= '0;
         bus.upd_target <= '0;
      end else begin
         bus.busy <= state_n == FLUSH;
         bus.redirect_valid <= fire;
         bus.redirect_pc <= fire ? win_pc : '0;
         bus.upd_valid <= run ? keep : '0;
         bus.upd_taken <= run ? keep & tk : '0;
         bus.upd_is_branch <= run ? keep & br : '0;
         bus.upd_is_jump <= run ? keep & jmp : '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            bus.upd_pc[i*XLEN +: XLEN] <= (run && keep[i]) ? bus.in_pc[i*XLEN +: XLEN] : '0;
            bus.upd_target[i*XLEN +: XLEN] <= (run && keep[i]) ? tgt[i] : '0;
         end
      end
   end
`ifdef BRANCH_STATS_EN
   logic [32:0] sb_sum;
   assign sb_sum = {1'b0, stat_branches} + 33'($countones(keep & {NUM_LANES{run}}));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches <= '0;
         stat_mispredicts <= '0;
      end else begin
         stat_branches <= sb_sum[32] ? '1 : sb_sum[31:0];
         stat_mispredicts <= stat_mispredicts + 32'(fire && stat_mispredicts != '1);
      end
   end
`endif
endmodule
